// File: rtl/meas_pkg.sv
// Shared definitions for the period measurement blocks: FSM states,
// default sizing and the saturation limit helper.
package meas_pkg;

    typedef enum logic {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } meas_state_t;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Largest value a w-bit unsigned counter can hold before it would wrap.
    function automatic longint unsigned max_count(input int w);
        return (64'(1) << w) - 64'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a
// rising-edge detector; reusable wherever a slow async signal is captured.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous square wave in clk_in cycles.
// Optional high-time measurement is built when PERIOD_METER_DUTY_EN is defined.
module period_meter
    import meas_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic [WIDTH-1:0] high_time
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic s;
    logic rise;

    meas_state_t      state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] period_nx;
    logic             valid_nx;
    logic             timeout_nx;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .sig   (sig_in),
        .s     (s),
        .rise  (rise)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARM;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            period       <= period_nx;
            period_valid <= valid_nx;
            timeout      <= timeout_nx;
        end
    end

    // A rise coinciding with the saturated count is still a valid result.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        period_nx  = period;
        valid_nx   = 1'b0;
        timeout_nx = timeout;
        if (clr) begin
            state_nx   = ARM;
            cnt_nx     = '0;
            period_nx  = '0;
            timeout_nx = 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        cnt_nx   = ONE;
                        state_nx = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nx = cnt;
                        valid_nx  = 1'b1;
                        cnt_nx    = ONE;
                    end else if (cnt == MAX) begin
                        timeout_nx = 1'b1;
                        state_nx   = ARM;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                default: state_nx = ARM;
            endcase
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] high_q;

    // The arming rise also seeds hcnt so the first period's high time is complete.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            high_q <= '0;
        end else if (clr) begin
            hcnt   <= '0;
            high_q <= '0;
        end else if (rise) begin
            if (state == MEASURE) begin
                high_q <= hcnt;
            end
            hcnt <= ONE;
        end else if (state == MEASURE && hcnt != MAX) begin
            hcnt <= hcnt + WIDTH'(s);
        end
    end

    assign high_time = high_q;
`else
    logic duty_unused;
    assign duty_unused = s;
    assign high_time   = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: a WIDTH=16 and a WIDTH=4 instance,
// table-driven patterns, hand-written corner sequences and random waves.
module tb_period_meter;

`ifdef PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    localparam int MAX16 = 65535;
    localparam int MAX4  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig16 = 1'b0, clr16 = 1'b0;
    logic        sig4 = 1'b0, clr4 = 1'b0;
    logic [15:0] period16, high16;
    logic        valid16, timeout16;
    logic [3:0]  period4, high4;
    logic        valid4, timeout4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    period_meter #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig16), .clr(clr16),
        .period(period16), .period_valid(valid16), .timeout(timeout16),
        .high_time(high16)
    );

    period_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig4), .clr(clr4),
        .period(period4), .period_valid(valid4), .timeout(timeout4),
        .high_time(high4)
    );

    // Edge-gap reference: an edge driven at tick c is seen by the meter at
    // tick c+2; results are the gaps between seen edges.
    typedef struct {
        logic [3:0] hist;
        bit         have;
        int         el;
        int         high;
        int         period;
        int         high_time;
        bit         valid;
        bit         timeout;
    } model_t;

    model_t m16, m4;

    function automatic model_t model_reset(input bit sig);
        model_t n;
        n.hist = {3'b000, sig};
        n.have = 1'b0;
        n.el = 0;
        n.high = 0;
        n.period = 0;
        n.high_time = 0;
        n.valid = 1'b0;
        n.timeout = 1'b0;
        return n;
    endfunction

    function automatic model_t model_step(input model_t m, input bit sig, input bit clr, input int maxv);
        model_t n = m;
        bit rise, s;
        n.hist = {m.hist[2:0], sig};
        s = n.hist[2];
        rise = n.hist[2] & ~n.hist[3];
        n.valid = 1'b0;
        if (m.have) n.el = m.el + 1;
        if (clr) begin
            n.have = 1'b0;
            n.period = 0;
            n.high_time = 0;
            n.timeout = 1'b0;
        end else if (rise) begin
            if (m.have) begin
                n.period = n.el;
                n.high_time = DUTY ? m.high : 0;
                n.valid = 1'b1;
            end
            n.have = 1'b1;
            n.el = 0;
            n.high = 1;
        end else if (m.have) begin
            if (n.el == maxv) begin
                n.timeout = 1'b1;
                n.have = 1'b0;
            end else begin
                n.high = m.high + int'(s);
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag, input model_t m, input logic [31:0] p,
                                 input logic v, input logic t, input logic [31:0] h);
        chk({tag, ".period"}, p, m.period);
        chk({tag, ".period_valid"}, {31'b0, v}, {31'b0, m.valid});
        chk({tag, ".timeout"}, {31'b0, t}, {31'b0, m.timeout});
        chk({tag, ".high_time"}, h, m.high_time);
    endtask

    task automatic tick(input bit a16, input bit c16, input bit a4, input bit c4);
        @(negedge clk);
        compare_model("d16", m16, {16'b0, period16}, valid16, timeout16, {16'b0, high16});
        compare_model("d4", m4, {28'b0, period4}, valid4, timeout4, {28'b0, high4});
        sig16 = a16; clr16 = c16; sig4 = a4; clr4 = c4;
        if (!rst_n) begin
            m16 = model_reset(a16);
            m4  = model_reset(a4);
        end else begin
            m16 = model_step(m16, a16, c16, MAX16);
            m4  = model_step(m4, a4, c4, MAX4);
        end
    endtask

    task automatic drv(input bit on4, input bit v, input bit c);
        if (on4) tick(1'b0, 1'b0, v, c);
        else     tick(v, c, 1'b0, 1'b0);
    endtask

    task automatic prelude(input bit on4);
        drv(on4, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drv(on4, 1'b0, 1'b0);
    endtask

    task automatic drive_pattern(input bit on4, input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) drv(on4, 1'b1, 1'b0);
            for (int i = 0; i < lo; i++) drv(on4, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) drv(on4, 1'b1, 1'b0);
    endtask

    typedef struct {
        bit on4;
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
        bit exp_timeout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0,   8,  8, 2,  16,   8, 1'b0};
        vecs[1] = '{1'b0,   5, 11, 2,  16,   5, 1'b0};
        vecs[2] = '{1'b0,   1,  1, 3,   2,   1, 1'b0};
        vecs[3] = '{1'b0,   3,  7, 2,  10,   3, 1'b0};
        vecs[4] = '{1'b0, 100, 23, 2, 123, 100, 1'b0};
        vecs[5] = '{1'b1,   7,  8, 2,  15,   7, 1'b0};
        vecs[6] = '{1'b1,   1, 15, 1,   0,   0, 1'b1};
        vecs[7] = '{1'b1,   2,  4, 2,   6,   2, 1'b0};

        m16 = model_reset(1'b0);
        m4  = model_reset(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            prelude(vecs[k].on4);
            drive_pattern(vecs[k].on4, vecs[k].hi, vecs[k].lo, vecs[k].reps);
            if (vecs[k].on4) begin
                chk($sformatf("vec%0d.period", k), {28'b0, period4}, vecs[k].exp_period);
                chk($sformatf("vec%0d.timeout", k), {31'b0, timeout4}, {31'b0, vecs[k].exp_timeout});
                chk($sformatf("vec%0d.high_time", k), {28'b0, high4}, DUTY ? vecs[k].exp_high : 0);
            end else begin
                chk($sformatf("vec%0d.period", k), {16'b0, period16}, vecs[k].exp_period);
                chk($sformatf("vec%0d.timeout", k), {31'b0, timeout16}, {31'b0, vecs[k].exp_timeout});
                chk($sformatf("vec%0d.high_time", k), {16'b0, high16}, DUTY ? vecs[k].exp_high : 0);
            end
        end

        // clr lands on the same cycle as a rise: the rise must be dropped.
        prelude(1'b0);
        drive_pattern(1'b0, 8, 8, 1);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 1'b0);
        chk("clr_rise.period", {16'b0, period16}, 0);
        chk("clr_rise.timeout", {31'b0, timeout16}, 0);
        drv(1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0);
        drive_pattern(1'b0, 5, 5, 1);
        chk("clr_after.period", {16'b0, period16}, 10);

        // Asynchronous reset between edges, released away from the clock edge.
        prelude(1'b0);
        drive_pattern(1'b0, 8, 8, 1);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        m16 = model_reset(sig16);
        m4  = model_reset(sig4);
        #1;
        chk("rst.period", {16'b0, period16}, 0);
        chk("rst.valid", {31'b0, valid16}, 0);
        chk("rst.timeout", {31'b0, timeout4}, 0);
        chk("rst.high_time", {16'b0, high16}, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        drive_pattern(1'b0, 8, 8, 1);
        chk("rst_after.period", {16'b0, period16}, 16);

        begin
            int r16 = 1, r4 = 1;
            bit l16 = 1'b0, l4 = 1'b0;
            bit c16, c4;
            for (int i = 0; i < 4000; i++) begin
                r16--;
                if (r16 == 0) begin
                    l16 = ~l16;
                    r16 = int'($urandom_range(1, 30));
                end
                r4--;
                if (r4 == 0) begin
                    l4 = ~l4;
                    r4 = int'($urandom_range(1, 12));
                end
                c16 = ($urandom_range(0, 299) == 0);
                c4  = ($urandom_range(0, 299) == 0);
                tick(l16, c16, l4, c4);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
